// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and default passcode for the arm controller
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ALARM    = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  localparam int          DEF_CODE_W = 10;
  localparam logic [9:0]  DEF_CODE   = 10'h112;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector on a level input
// Previous-value register resets high so a level held across reset release is not an edge.
module rise_detect (
  input  logic iCLK,
  input  logic iRST,
  input  logic iD,
  output logic oRise
);

  logic prev_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= iD;
    end
  end

  assign oRise = iD & ~prev_q;

endmodule

// File: rtl/passcode_arm_ctrl.sv
// rtl/passcode_arm_ctrl.sv - passcode arm/disarm FSM with wrong-entry lockout
// Outputs are registered decodes of the next state, so they follow the input cycle by one clock.
module passcode_arm_ctrl
  import alarm_pkg::*;
#(
  parameter int                CODE_W      = DEF_CODE_W,
  parameter logic [CODE_W-1:0] CODE        = CODE_W'(DEF_CODE),
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCKOUT_CYC = 50_000_000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [CODE_W-1:0] iCode,
  input  logic              iEnter,
  input  logic              iSensor,
  input  logic              iTD_Stable,
  output logic              oArmed,
  output logic              oAlarm,
  output logic              oLocked,
  output logic              oVideo_On,
  output logic [3:0]        oTries
);

  localparam int                  TIMER_W    = $clog2(LOCKOUT_CYC + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(LOCKOUT_CYC - 1);
  localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);
  localparam logic [3:0]          TRIES_MAX  = 4'(MAX_TRIES);

  state_t             state_q, next_state;
  logic [3:0]         tries_q, tries_d, tries_inc;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               entry, correct, wrong;
  logic               armed_d, alarm_d, locked_d, video_d;

  rise_detect u_enter_edge (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iD    (iEnter),
    .oRise (entry)
  );

  assign correct   = entry & (iCode == CODE);
  assign wrong     = entry & (iCode != CODE);
  assign tries_inc = (tries_q == TRIES_MAX) ? tries_q : tries_q + 4'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= DISARMED;
      tries_q   <= '0;
      timer_q   <= '0;
      oArmed    <= 1'b0;
      oAlarm    <= 1'b0;
      oLocked   <= 1'b0;
      oVideo_On <= 1'b0;
      oTries    <= '0;
    end else begin
      state_q   <= next_state;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      oArmed    <= armed_d;
      oAlarm    <= alarm_d;
      oLocked   <= locked_d;
      oVideo_On <= video_d;
      oTries    <= tries_d;
    end
  end

  // Disarm outranks everything; a wrong entry that trips lockout outranks the sensor.
  always_comb begin
    next_state = state_q;
    tries_d    = tries_q;
    timer_d    = timer_q;
    case (state_q)
      DISARMED: begin
        if (correct) next_state = ARMED;
      end
      ARMED, ALARM: begin
        if (correct) begin
          next_state = DISARMED;
          tries_d    = '0;
        end else if (wrong) begin
          tries_d = tries_inc;
          if (tries_inc == TRIES_MAX) begin
            next_state = LOCKOUT;
            timer_d    = TIMER_LOAD;
          end else if (state_q == ARMED && iSensor) begin
            next_state = ALARM;
          end
        end else if (state_q == ARMED && iSensor) begin
          next_state = ALARM;
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          next_state = ALARM;
          tries_d    = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: next_state = DISARMED;
    endcase
  end

  always_comb begin
    armed_d  = (next_state == ARMED);
    alarm_d  = (next_state == ALARM) | (next_state == LOCKOUT);
    locked_d = (next_state == LOCKOUT);
    video_d  = (next_state != DISARMED) & iTD_Stable;
  end

endmodule

// File: doc/passcode_arm_ctrl.md
PASSCODE_ARM_CTRL -- requirements
Module: passcode_arm_ctrl

Interface
REQ-001 The block SHALL have parameter CODE_W, default 10, giving the passcode width in bits.
REQ-002 The block SHALL have parameter CODE, default 10'h112 (SW[1,4,8]), giving the accepted passcode.
REQ-003 The block SHALL have parameter MAX_TRIES, default 3, giving the wrong entries tolerated before lockout (range 1..15).
REQ-004 The block SHALL have parameter LOCKOUT_CYC, default 50_000_000, giving the lockout duration in iCLK cycles (at least 1).
REQ-005 Port iCLK  in  1  single clock; all state changes on its rising edge.
REQ-006 Port iRST  in  1  reset, synchronous, active-high.
REQ-007 Port iCode  in  CODE_W  passcode switch inputs, already synchronised.
REQ-008 Port iEnter  in  1  enter key level, active-high, debounced upstream.
REQ-009 Port iSensor  in  1  intrusion sensor level, active-high.
REQ-010 Port iTD_Stable  in  1  video decoder locked indication.
REQ-011 Port oArmed  out  1  high in ARMED.
REQ-012 Port oAlarm  out  1  high in ALARM or LOCKOUT.
REQ-013 Port oLocked  out  1  high in LOCKOUT.
REQ-014 Port oVideo_On  out  1  gate for the SDRAM and decoder enables.
REQ-015 Port oTries  out  4  current wrong-entry count.

Function
REQ-016 An entry event SHALL occur on a cycle where iEnter=1 and the registered previous iEnter=0; an entry is correct when iCode==CODE on that cycle.
REQ-017 The FSM SHALL have the states DISARMED, ARMED, ALARM and LOCKOUT.
REQ-018 DISARMED: a correct entry SHALL go to ARMED; a wrong entry SHALL be ignored and SHALL NOT change oTries.
REQ-019 ARMED: iSensor=1 SHALL go to ALARM; a correct entry SHALL go to DISARMED and clear oTries.
REQ-020 ALARM: a correct entry SHALL go to DISARMED and clear oTries; iSensor SHALL be ignored.
REQ-021 ARMED or ALARM, wrong entry: oTries SHALL increment; if the incremented value equals MAX_TRIES, the FSM SHALL go to LOCKOUT and load the lockout timer with LOCKOUT_CYC-1; otherwise the state SHALL be unchanged.
REQ-022 LOCKOUT: entries SHALL be ignored; the timer SHALL decrement each cycle; on the cycle it reads 0, the FSM SHALL go to ALARM and clear oTries.
REQ-023 LOCKOUT SHALL therefore last exactly LOCKOUT_CYC cycles.
REQ-024 In ARMED, a correct entry and iSensor=1 on the same cycle SHALL result in DISARMED (disarm wins).
REQ-025 In ARMED, a wrong entry and iSensor=1 on the same cycle: the lockout transition SHALL win if triggered; otherwise the FSM SHALL go to ALARM and oTries SHALL increment.
REQ-026 oTries SHALL saturate at MAX_TRIES and SHALL NOT wrap.
REQ-027 The timer width SHALL be $clog2(LOCKOUT_CYC+1).
REQ-028 All outputs SHALL be registered Moore decodes of the next state: they appear 1 cycle after the entry/sensor cycle.
REQ-029 oVideo_On SHALL be registered as (next_state != DISARMED) & iTD_Stable, with 1 cycle latency from iTD_Stable.

Reset
REQ-030 While iRST=1 the state SHALL be DISARMED, the timer 0, oTries 0, and all outputs 0.
REQ-031 While iRST=1 the previous-iEnter register SHALL be 1, so an iEnter held across reset release creates no entry.
REQ-032 Reset asserted mid-LOCKOUT SHALL abort the lockout immediately; the next cycle is in DISARMED.

Structure
REQ-033 The state enum, its 2-bit encoding and the default CODE/CODE_W SHALL live in the shared package alarm_pkg.
REQ-034 Edge detection SHALL be the sub-module rise_detect (iCLK, iRST, iD, oRise), with reset value 1 on its internal register.
REQ-035 The lockout timer SHALL be inline.

Verification (CODE=10'h112, MAX_TRIES=3, LOCKOUT_CYC=8)
REQ-036 iCode=10'h112, iEnter pulse from reset -> oArmed=1 on the next cycle; with iTD_Stable=1, oVideo_On=1 on the same cycle.
REQ-037 Armed, then iSensor=1 for 1 cycle -> oAlarm=1 next cycle; then a correct entry -> oAlarm=0, oArmed=0, oVideo_On=0.
REQ-038 Armed, then three entries with 10'h000 -> oTries=1 then 2, then oLocked=1; oLocked stays high exactly 8 cycles, then oAlarm=1, oLocked=0, oTries=0.
REQ-039 During LOCKOUT a correct entry -> no state change; iRST pulse at lockout cycle 4 -> DISARMED, all outputs 0 next cycle.
REQ-040 Armed, correct entry and iSensor=1 on the same cycle -> DISARMED; iEnter held high through reset release -> no arming.
